fnd_scan_ctrl: RTL and testbench

Four-digit common-anode 7-segment scan driver that sits directly downstream of the 14-bit decimal counter and consumes its `count_data` word. It saturates the binary value to 9999 and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes the four digits onto `fnd_data`/`fnd_com` at a parameterised scan rate. Display content is updated atomically once per conversion, so digits never show a mix of old and new values.

---
 rtl/fnd_pkg.sv | 48 ++++
 rtl/fnd_scan_ctrl_bin2bcd_seq.sv | 86 ++++++++
 rtl/fnd_scan_ctrl.sv | 95 +++++++++
 tb/tb_fnd_scan_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants, converter state type and segment decoder for the
// four-digit 7-segment scan driver.
package fnd_pkg;

    localparam int FND_DIGITS = 4;
    localparam int BCD_W      = 16;
    localparam int BIN_W      = 14;
    localparam int DISP_MAX   = 9999;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp stays dark.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_LOAD  = 2'd1,
        CONV_SHIFT = 2'd2,
        CONV_DONE  = 2'd3
    } conv_state_e;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: saturating LOAD, 14 SHIFT cycles,
// one DONE cycle that presents the result alongside a done pulse.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    conv_state_e      state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0] adj_s;
    logic [BCD_W+BIN_W-1:0] shift_s;

    // Next-state, add-3 correction and shift datapath.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
        shift_s = {adj_s, bin_q} << 1;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    state_d = CONV_LOAD;
                end else begin
                    state_d = CONV_IDLE;
                end
            end
            CONV_LOAD: begin
                if (bin > BIN_W'(DISP_MAX)) begin
                    bin_d = BIN_W'(DISP_MAX);
                end else begin
                    bin_d = bin;
                end
                bcd_d   = {BCD_W{1'b0}};
                cnt_d   = 4'd0;
                state_d = CONV_SHIFT;
            end
            CONV_SHIFT: begin
                {bcd_d, bin_d} = shift_s;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = CONV_DONE;
                end else begin
                    state_d = CONV_SHIFT;
                end
            end
            CONV_DONE: state_d = CONV_IDLE;
            default:   state_d = CONV_IDLE;
        endcase
    end

    // Converter state; reset leaves a conversion pending so the display
    // fills as soon as reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CONV_LOAD;
            bin_q   <= {BIN_W{1'b0}};
            bcd_q   <= {BCD_W{1'b0}};
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done = (state_q == CONV_DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit common-anode 7-segment scan driver with saturating BCD display.
// Define FND_LZB_EN to blank leading zeros on digits 3..1.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] count_data,
    output logic [7:0]  fnd_data,
    output logic [3:0]  fnd_com
);

    localparam int TMR_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       dig_sel_q, dig_sel_d;
    logic [15:0]      disp_bcd_q, disp_bcd_d;
    logic [7:0]       fnd_data_q, fnd_data_d;
    logic [3:0]       fnd_com_q, fnd_com_d;
    logic             slot_tick_s;
    logic             frame_start_s;
    logic             conv_done_s;
    logic [15:0]      conv_bcd_s;
    logic [3:0]       nib_s;
    logic             blank_s;

    assign slot_tick_s   = (tmr_q == TMR_W'(SCAN_DIV - 1));
    assign frame_start_s = slot_tick_s && (dig_sel_q == 2'd3);

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (frame_start_s),
        .bin   (count_data),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // Outputs are computed from next-cycle digit and display so that
    // segments and common lines switch together on the same edge.
    always_comb begin
        if (slot_tick_s) begin
            tmr_d     = {TMR_W{1'b0}};
            dig_sel_d = dig_sel_q + 2'd1;
        end else begin
            tmr_d     = tmr_q + TMR_W'(1);
            dig_sel_d = dig_sel_q;
        end
        if (conv_done_s) begin
            disp_bcd_d = conv_bcd_s;
        end else begin
            disp_bcd_d = disp_bcd_q;
        end
        nib_s = disp_bcd_d[{dig_sel_d, 2'b00} +: 4];
`ifdef FND_LZB_EN
        case (dig_sel_d)
            2'd3:    blank_s = (disp_bcd_d[15:12] == 4'd0);
            2'd2:    blank_s = (disp_bcd_d[15:8] == 8'd0);
            2'd1:    blank_s = (disp_bcd_d[15:4] == 12'd0);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
        if (blank_s) begin
            fnd_data_d = SEG_BLANK;
        end else begin
            fnd_data_d = seg_decode(nib_s);
        end
        fnd_com_d = ~(4'b0001 << dig_sel_d);
    end

    // Scan timer, digit index, display latch and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q      <= {TMR_W{1'b0}};
            dig_sel_q  <= 2'd0;
            disp_bcd_q <= 16'h0000;
            fnd_data_q <= SEG_0;
            fnd_com_q  <= 4'b1110;
        end else begin
            tmr_q      <= tmr_d;
            dig_sel_q  <= dig_sel_d;
            disp_bcd_q <= disp_bcd_d;
            fnd_data_q <= fnd_data_d;
            fnd_com_q  <= fnd_com_d;
        end
    end

    assign fnd_data = fnd_data_q;
    assign fnd_com  = fnd_com_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: vector table, corner sequences and
// randomized count_data against an arithmetic display model.
module tb_fnd_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;
`ifdef FND_LZB_EN
    localparam bit         LZB = 1'b1;
    localparam logic [7:0] ZB  = 8'hFF;
`else
    localparam bit         LZB = 1'b0;
    localparam logic [7:0] ZB  = 8'hC0;
`endif

    typedef struct {
        logic [13:0] cd;
        logic [31:0] segs;   // {slot3, slot2, slot1, slot0}
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] count_data = 14'd1234;
    logic [7:0]  fnd_data;
    logic [3:0]  fnd_com;

    int n_pass = 0;
    int n_chk  = 0;
    int k, trig, pend_val, disp_val;
    logic [7:0] seg_tab [10];
    vec_t vecs [8];

    fnd_scan_ctrl #(.SCAN_DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_data (count_data),
        .fnd_data   (fnd_data),
        .fnd_com    (fnd_com)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t (k=%0d)", name, act, exp, $time, k);
    endtask

    function automatic logic [7:0] exp_seg(input int val, input int dig);
        int p = 1;
        for (int i = 0; i < dig; i++) p = p * 10;
        if (LZB && dig > 0 && val < p) return 8'hFF;
        return seg_tab[(val / p) % 10];
    endfunction

    function automatic logic [3:0] exp_com(input int kk);
        logic [3:0] m;
        m = 4'b0001 << ((kk / DIV) % 4);
        return ~m;
    endfunction

    // One clock: update the model from the spec's timing rules, then compare.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        if (k == trig + 1) pend_val = (int'(count_data) > 9999) ? 9999 : int'(count_data);
        if (k == trig + 16) disp_val = pend_val;
        if ((k % FRAME == 0) && (k >= trig + 17)) trig = k;
        chk("com", {4'h0, fnd_com}, {4'h0, exp_com(k)});
        chk("data", fnd_data, exp_seg(disp_val, (k / DIV) % 4));
        chk("onehot", 8'($countones(~fnd_com)), 8'd1);
    endtask

    task automatic do_reset(input logic [13:0] cd);
        @(posedge clk);
        #1;
        reset = 1'b1;
        count_data = cd;
        #1;
        chk("rst_com", {4'h0, fnd_com}, 8'h0E);
        chk("rst_data", fnd_data, 8'hC0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0; trig = 0; pend_val = 0; disp_val = 0;
    endtask

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        vecs[0] = '{14'd1234,  {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1] = '{14'd9999,  {8'h90, 8'h90, 8'h90, 8'h90}};
        vecs[2] = '{14'd16383, {8'h90, 8'h90, 8'h90, 8'h90}};
        vecs[3] = '{14'd10000, {8'h90, 8'h90, 8'h90, 8'h90}};
        vecs[4] = '{14'd0,     {ZB, ZB, ZB, 8'hC0}};
        vecs[5] = '{14'd7,     {ZB, ZB, ZB, 8'hF8}};
        vecs[6] = '{14'd42,    {ZB, ZB, 8'h99, 8'hA4}};
        vecs[7] = '{14'd805,   {ZB, 8'h80, 8'hC0, 8'h92}};
        k = 0; trig = 0; pend_val = 0; disp_val = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("init_com", {4'h0, fnd_com}, 8'h0E);
        chk("init_data", fnd_data, 8'hC0);

        // First frame after release shows the freshly converted value.
        for (int i = 0; i < 8; i++) begin
            do_reset(vecs[i].cd);
            repeat (16) step();
            for (int s = 0; s < 4; s++) begin
                chk("vec_slot", fnd_data, vecs[i].segs[8*s +: 8]);
                repeat (DIV) step();
            end
        end

        // Change mid-frame: old value holds until the next conversion lands.
        do_reset(14'd9999);
        repeat (18) step();
        count_data = 14'd0;
        repeat (2) step();
        chk("hold_old", fnd_data, 8'h90);
        repeat (27) step();
        chk("hold_last", fnd_data, 8'h90);
        step();
        chk("new_slot0", fnd_data, 8'hC0);
        repeat (4) step();
        chk("new_slot1", fnd_data, ZB);

        // Reset during SHIFT aborts the conversion.
        do_reset(14'd1234);
        repeat (40) step();
        reset = 1'b1;
        #1;
        chk("midrst_com", {4'h0, fnd_com}, 8'h0E);
        chk("midrst_data", fnd_data, 8'hC0);
        @(posedge clk);
        #1;
        chk("midrst_hold", fnd_data, 8'hC0);
        reset = 1'b0;
        k = 0; trig = 0; pend_val = 0; disp_val = 0;
        repeat (15) step();
        chk("pre_done", fnd_data, ZB);
        step();
        chk("post_done", fnd_data, 8'h99);

        // Randomized count_data against the model, well over ten frames.
        do_reset(14'd5678);
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 2) == 0) count_data = 14'($urandom_range(9990, 16383));
                else count_data = 14'($urandom_range(0, 9999));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
